// File: rtl/octa16_pkg.sv
// rtl/octa16_pkg.sv - shared widths, ALU op codes and FSM encoding for alu_arbiter
package octa16_pkg;

  localparam int DATA_W   = 8;
  localparam int CTRL_W   = 3;
  localparam int REQ_ID_W = 1;

  localparam logic [CTRL_W-1:0] OP_LOGIC  = 3'b000;
  localparam logic [CTRL_W-1:0] OP_ADDSUB = 3'b011;
  localparam logic [CTRL_W-1:0] OP_SHIFT  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]   rs1;
    logic [DATA_W-1:0]   rs2;
    logic [CTRL_W-1:0]   ctrl;
    logic                flag;
    logic [REQ_ID_W-1:0] id;
  } op_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two-requester request bus plus response bus for alu_arbiter
interface alu_arbiter_if;
  import octa16_pkg::*;

  logic                req0_valid;
  logic                req0_ready;
  logic [DATA_W-1:0]   req0_rs1;
  logic [DATA_W-1:0]   req0_rs2;
  logic [CTRL_W-1:0]   req0_ctrl;
  logic                req0_flag;

  logic                req1_valid;
  logic                req1_ready;
  logic [DATA_W-1:0]   req1_rs1;
  logic [DATA_W-1:0]   req1_rs2;
  logic [CTRL_W-1:0]   req1_ctrl;
  logic                req1_flag;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [REQ_ID_W-1:0] rsp_id;
  logic [DATA_W-1:0]   rsp_out;
  logic                rsp_overflow;

  modport master (
    output req0_valid, req0_rs1, req0_rs2, req0_ctrl, req0_flag,
    output req1_valid, req1_rs1, req1_rs2, req1_ctrl, req1_flag,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_out, rsp_overflow,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_rs1, req0_rs2, req0_ctrl, req0_flag,
    input  req1_valid, req1_rs1, req1_rs2, req1_ctrl, req1_flag,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_out, rsp_overflow,
    input  rsp_ready
  );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - 8-bit combinational ALU: NOR/NAND, ADD/SUB with carry, SHR/SHL
module alu
  import octa16_pkg::*;
(
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flag_i,
  output logic [DATA_W-1:0] out_o,
  output logic              overflow_o
);

  logic [DATA_W:0] sum;

  // SUB reuses the adder as rs1 + ~rs2 + 1; overflow is the adder carry-out
  always_comb begin
    sum = {1'b0, rs1_i} + {1'b0, (flag_i ? ~rs2_i : rs2_i)} + {{DATA_W{1'b0}}, flag_i};
  end

  always_comb begin
    out_o      = '0;
    overflow_o = 1'b0;
    case (ctrl_i)
      OP_LOGIC:  out_o = flag_i ? ~(rs1_i & rs2_i) : ~(rs1_i | rs2_i);
      OP_ADDSUB: begin
        out_o      = sum[DATA_W-1:0];
        overflow_o = sum[DATA_W];
      end
      OP_SHIFT:  out_o = flag_i ? (rs1_i << rs2_i[2:0]) : (rs1_i >> rs2_i[2:0]);
      default: begin
        out_o      = '0;
        overflow_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - arbitrates two requesters onto one ALU with IDLE/EXEC/RESP FSM
// ALU_ARB_RR_EN selects round-robin arbitration; undefined gives fixed priority to requester 0.
module alu_arbiter
  import octa16_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus,
  output logic         busy
);

  state_e              state_q, state_d;
  op_t                 op_q;
  logic [DATA_W-1:0]   rsp_out_q;
  logic                rsp_ovf_q;
  logic [REQ_ID_W-1:0] rsp_id_q;
  logic [REQ_ID_W-1:0] gnt_id;
  logic                accept;
  logic                in_idle;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_ovf;

`ifdef ALU_ARB_RR_EN
  logic [REQ_ID_W-1:0] last_q;

  // Pointer starts at 1 so requester 0 wins the first contested grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt_id;
    end
  end

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = ~bus.req0_valid;
    end
  end
`else
  always_comb begin
    gnt_id = ~bus.req0_valid;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)        state_d = ST_EXEC;
      ST_EXEC:                    state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Readies are gated by rst_n so nothing is offered while reset is held
  always_comb begin
    in_idle        = rst_n && (state_q == ST_IDLE);
    bus.req0_ready = in_idle && (gnt_id == 1'b0) && bus.req0_valid;
    bus.req1_ready = in_idle && (gnt_id == 1'b1) && bus.req1_valid;
    accept         = bus.req0_ready || bus.req1_ready;
    bus.rsp_valid  = (state_q == ST_RESP);
    busy           = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if (accept) begin
      if (gnt_id == 1'b1) begin
        op_q <= '{rs1: bus.req1_rs1, rs2: bus.req1_rs2, ctrl: bus.req1_ctrl,
                  flag: bus.req1_flag, id: 1'b1};
      end else begin
        op_q <= '{rs1: bus.req0_rs1, rs2: bus.req0_rs2, ctrl: bus.req0_ctrl,
                  flag: bus.req0_flag, id: 1'b0};
      end
    end
  end

  alu u_alu (
    .rs1_i      (op_q.rs1),
    .rs2_i      (op_q.rs2),
    .ctrl_i     (op_q.ctrl),
    .flag_i     (op_q.flag),
    .out_o      (alu_out),
    .overflow_o (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_out_q <= '0;
      rsp_ovf_q <= 1'b0;
      rsp_id_q  <= '0;
    end else if (state_q == ST_EXEC) begin
      rsp_out_q <= alu_out;
      rsp_ovf_q <= alu_ovf;
      rsp_id_q  <= op_q.id;
    end
  end

  assign bus.rsp_out      = rsp_out_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_id       = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter (both ALU_ARB_RR_EN builds)
module tb_alu_arbiter;
  import octa16_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       ovf;
    logic       id;
  } exp_t;

  exp_t sb_q[$];
  logic grant_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_edge = -10;
  logic prev_rsp_valid = 1'b0;
  logic [7:0] cap_out;
  logic       cap_ovf;
  logic       seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] c, input logic f, input logic id);
    exp_t e;
    logic [8:0] s;
    e.out = 8'h00;
    e.ovf = 1'b0;
    e.id  = id;
    case (c)
      3'b000: e.out = f ? ~(a & b) : ~(a | b);
      3'b011: begin
        if (f) s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        else   s = {1'b0, a} + {1'b0, b};
        e.out = s[7:0];
        e.ovf = s[8];
      end
      3'b100: e.out = f ? (a << b[2:0]) : (a >> b[2:0]);
      default: ;
    endcase
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_valid && bus.req0_ready) begin
        sb_q.push_back(model(bus.req0_rs1, bus.req0_rs2, bus.req0_ctrl, bus.req0_flag, 1'b0));
        grant_q.push_back(1'b0);
        acc_edge = cyc + 1;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb_q.push_back(model(bus.req1_rs1, bus.req1_rs2, bus.req1_ctrl, bus.req1_flag, 1'b1));
        grant_q.push_back(1'b1);
        acc_edge = cyc + 1;
      end
      if (bus.rsp_valid && !prev_rsp_valid)
        check("rsp_latency_edge", cyc, acc_edge + 1);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_id", bus.rsp_id, mon_e.id);
          check("rsp_out", bus.rsp_out, mon_e.out);
          check("rsp_overflow", bus.rsp_overflow, mon_e.ovf);
        end
      end
    end
    prev_rsp_valid = bus.rsp_valid;
  end

  task automatic issue(input int n, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] c, input logic f);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    if (n == 0) begin
      bus.req0_rs1 = a; bus.req0_rs2 = b; bus.req0_ctrl = c; bus.req0_flag = f;
      bus.req0_valid = 1'b1;
    end else begin
      bus.req1_rs1 = a; bus.req1_rs2 = b; bus.req1_ctrl = c; bus.req1_flag = f;
      bus.req1_valid = 1'b1;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (n == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check("req_accepted", got, 1);
    @(posedge clk); #1;
    if (n == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] c;
    bus.req0_valid = 1'b1; bus.req0_rs1 = '0; bus.req0_rs2 = '0; bus.req0_ctrl = '0; bus.req0_flag = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_rs1 = '0; bus.req1_rs2 = '0; bus.req1_ctrl = '0; bus.req1_flag = 1'b0;
    bus.rsp_ready  = 1'b1;

    #12;
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_req1_ready", bus.req1_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_out", bus.rsp_out, 0);
    check("rst_rsp_overflow", bus.rsp_overflow, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, 8'h05, 8'h03, 3'b011, 1'b0);
    issue(1, 8'h80, 8'h80, 3'b011, 1'b0);
    issue(1, 8'h05, 8'h03, 3'b011, 1'b1);
    issue(0, 8'h81, 8'h0B, 3'b100, 1'b1);
    issue(1, 8'hF0, 8'h0C, 3'b100, 1'b0);
    issue(0, 8'hF0, 8'h3C, 3'b000, 1'b1);
    issue(1, 8'hF0, 8'h3C, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       c = 3'b000;
        1:       c = 3'b011;
        2:       c = 3'b100;
        default: c = 3'($urandom_range(0, 7));
      endcase
      issue(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), c, 1'($urandom));
    end
    drain();

    // Both requesters valid continuously
    grant_q.delete();
    @(posedge clk); #1;
    bus.req0_rs1 = 8'h10; bus.req0_rs2 = 8'h01; bus.req0_ctrl = 3'b011; bus.req0_flag = 1'b0;
    bus.req1_rs1 = 8'h20; bus.req1_rs2 = 8'h02; bus.req1_ctrl = 3'b011; bus.req1_flag = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("grant_count_ge4", (grant_q.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (grant_q.size() > i) begin
`ifdef ALU_ARB_RR_EN
        check("grant_order_rr", grant_q[i], i % 2);
`else
        check("grant_order_fixed", grant_q[i], 0);
`endif
      end
    end
    drain();

    // Response stall with unsupported op code
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    issue(0, 8'h55, 8'hAA, 3'b111, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    check("stall_rsp_valid_seen", seen, 1);
    cap_out = bus.rsp_out;
    cap_ovf = bus.rsp_overflow;
    check("badop_out", cap_out, 0);
    check("badop_overflow", cap_ovf, 0);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_rsp_valid", bus.rsp_valid, 1);
      check("stall_rsp_out", bus.rsp_out, cap_out);
      check("stall_rsp_overflow", bus.rsp_overflow, cap_ovf);
      check("stall_rsp_id", bus.rsp_id, 0);
      check("stall_ready0", bus.req0_ready, 0);
      check("stall_ready1", bus.req1_ready, 0);
      check("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();

    // Reset while an operation is in EXEC
    @(posedge clk); #1;
    bus.req0_rs1 = 8'h11; bus.req0_rs2 = 8'h22; bus.req0_ctrl = 3'b011; bus.req0_flag = 1'b0;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rsp_valid", bus.rsp_valid, 0);
    check("arst_rsp_out", bus.rsp_out, 0);
    check("arst_rsp_id", bus.rsp_id, 0);
    check("arst_rsp_overflow", bus.rsp_overflow, 0);
    check("arst_ready0", bus.req0_ready, 0);
    check("arst_ready1", bus.req1_ready, 0);
    sb_q.delete();
    grant_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 10 && grant_q.size() == 0; i++) begin
      @(negedge clk); #1;
    end
    check("post_reset_grant_seen", (grant_q.size() > 0), 1);
    if (grant_q.size() > 0) check("post_reset_first_grant", grant_q[0], 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; the datapath is 8-bit, the op code is 3-bit and there are 2 requesters, all fixed.
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  out  1  (N=0,1) arbiter accepts requester N this cycle.
REQ-007 reqN_rs1, reqN_rs2  in  8 each  (N=0,1) operands.
REQ-008 reqN_ctrl  in  3 / reqN_flag  in  1  (N=0,1) ALU op code and variant flag.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer takes the result.
REQ-011 rsp_id  out  1  requester index owning the result.
REQ-012 rsp_out  out  8 / rsp_overflow  out  1  ALU result and overflow/carry.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 FSM SHALL have states IDLE, EXEC and RESP.
REQ-015 IDLE: reqN_ready SHALL be high only for the granted requester, granted only if its valid is high; it SHALL NOT depend on rsp_ready.
REQ-016 Handshake: accept = reqN_valid & reqN_ready at a rising edge; on accept, latch rs1/rs2/ctrl/flag/id and go to EXEC.
REQ-017 Both reqN_ready SHALL be low in EXEC and RESP.
REQ-018 EXEC: drive latched operands to the shared ALU and register out/overflow/id into rsp_* at the next edge; then go to RESP.
REQ-019 RESP: rsp_valid=1 with rsp_* stable until rsp_ready=1 at an edge; then go to IDLE.
REQ-020 Latency: accept at edge k SHALL give rsp_valid high from edge k+2; minimum issue interval is 3 cycles when rsp_ready is held high.
REQ-021 The ALU op codes SHALL be: 000 NAND when flag=1, NOR when flag=0; 011 SUB (rs1+~rs2+1) when flag=1, ADD when flag=0; 100 SHL when flag=1, SHR when flag=0, by rs2[2:0]; all other codes give out=0 and overflow=0.
REQ-022 An unsupported ctrl SHALL still complete normally, with rsp_out=0 and rsp_overflow=0.
REQ-023 Simultaneous valids: the requester is chosen per REQ-028/029; the loser's valid and operands must be held and are not lost.
REQ-024 A requester dropping valid before accept SHALL NOT be granted.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_overflow=0, busy=0, the last-grant pointer to 1 (so requester 0 wins first), and both reqN_ready low while rst_n is low.
REQ-026 An operation in flight at reset SHALL be discarded with no response.
REQ-027 Deassertion is synchronised by the system; the arbiter accepts from the first edge after release.

Configuration
REQ-028 With ALU_ARB_RR_EN defined: round-robin; when both are valid, grant the requester not granted last; the pointer updates only on accept.
REQ-029 With ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins; no pointer register is implemented.

Structure
REQ-030 Package octa16_pkg SHALL hold the op-code constants (OP_LOGIC=3'b000, OP_ADDSUB=3'b011, OP_SHIFT=3'b100), the FSM state encoding and REQ_ID_W=1.
REQ-031 One sub-module: the existing 8-bit ALU (module alu), instantiated once as u_alu and fed only from the latched operand registers.

Verification
REQ-032 req0 only: rs1=0x05, rs2=0x03, ctrl=011, flag=0, accepted at edge k -> rsp_valid at k+2, rsp_out=0x08, overflow=0, rsp_id=0.
REQ-033 req1 only: rs1=0x80, rs2=0x80, ctrl=011, flag=0 -> rsp_out=0x00, overflow=1, rsp_id=1; then rs1=0x05, rs2=0x03, flag=1 -> rsp_out=0x02, overflow=1.
REQ-034 Both valid continuously with rsp_ready=1: RR_EN defined -> grant order 0,1,0,1; RR_EN undefined -> 0,0,0,0 and req1 is never granted.
REQ-035 rsp_ready held low 5 cycles -> rsp_* stable, both readies low, busy=1; ctrl=111 -> rsp_out=0x00, overflow=0.
REQ-036 rst_n pulsed low in EXEC -> outputs go to reset values at once, no response appears, and req0 is granted first after release.
